// File: rtl/glyph_row_streamer.sv
// glyph_row_streamer: accepts (code,row) requests, reads one 8-pixel glyph
// row from the built-in 8x16 digit font and serialises it MSB-first.
// Parameters: SCALE (cycles per pixel 1..4), GAP_PX (blank pixels after a
// row 0..7), FIRST_CODE (first glyph code), NUM_GLYPHS (glyph count 1..10).
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_code/req_row
// request handshake; pix/pix_valid/pix_col/pix_last registered pixel stream;
// busy = not idle.
// Optional macro GLYPH_INVERT_EN adds req_invert, latched per request, which
// inverts every emitted pixel including gap pixels.
module glyph_row_streamer #(
    parameter int         SCALE      = 1,
    parameter int         GAP_PX     = 0,
    parameter logic [6:0] FIRST_CODE = 7'h30,
    parameter int         NUM_GLYPHS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_code,
    input  logic [3:0] req_row,
`ifdef GLYPH_INVERT_EN
    input  logic       req_invert,
`endif
    output logic       pix,
    output logic       pix_valid,
    output logic [2:0] pix_col,
    output logic       pix_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int         TOTAL    = (8 + GAP_PX) * SCALE;
    localparam logic [5:0] REM_INIT = 6'(TOTAL - 1);
    localparam logic [1:0] SCALE_M1 = 2'(SCALE - 1);

    state_t     state_q, state_d;
    logic [6:0] code_q, code_d;
    logic [3:0] row_q, row_d;
    logic       inv_q, inv_d;
    logic [6:0] shreg_q, shreg_d;
    logic [1:0] sub_q, sub_d;
    logic [5:0] rem_q, rem_d;
    logic       pix_d, pix_valid_d, pix_last_d;
    logic [2:0] pix_col_d;
    logic [7:0] row_data;
    logic       inv_in;
    logic       accept;

`ifdef GLYPH_INVERT_EN
    assign inv_in = req_invert;
`else
    assign inv_in = 1'b0;
`endif

    // Font rows 2..11 of each digit, row 2 in the top byte; rows 0,1,12..15
    // and codes outside the glyph range are blank.
    function automatic logic [7:0] glyph_row(input logic [6:0] code,
                                             input logic [3:0] row);
        logic [79:0] rows;
        logic [6:0]  off;
        logic [3:0]  r;
        int          base;
        off  = code - FIRST_CODE;
        r    = row - 4'd2;
        rows = '0;
        if (code >= FIRST_CODE && off < 7'(NUM_GLYPHS)) begin
            unique case (off)
                7'd0: rows = 80'h386CC6C6C6C6C6C66C38;
                7'd1: rows = 80'h18387818181818187E7E;
                7'd2: rows = 80'h7CC6060C183060C0C6FE;
                7'd3: rows = 80'h7CC606063C060606C67C;
                7'd4: rows = 80'h0C1C3C6CCCFE0C0C0C1E;
                7'd5: rows = 80'hFEC0C0C0FC060606C67C;
                7'd6: rows = 80'h3860C0C0FCC6C6C6C67C;
                7'd7: rows = 80'hFEC606060C1830303030;
                7'd8: rows = 80'h7CC6C6C67CC6C6C6C67C;
                7'd9: rows = 80'h7CC6C6C67E0606060C78;
                default: rows = '0;
            endcase
        end
        glyph_row = 8'h00;
        if (row >= 4'd2 && row <= 4'd11) begin
            base      = 79 - 8 * int'(r);
            glyph_row = rows[base -: 8];
        end
    endfunction

    // pix_last marks the only streaming cycle that can take a new request.
    assign req_ready = !reset && (state_q == IDLE || pix_last);
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != IDLE);
    assign row_data  = glyph_row(code_q, row_q);

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        row_d       = row_q;
        inv_d       = inv_q;
        shreg_d     = shreg_q;
        sub_d       = sub_q;
        rem_d       = rem_q;
        pix_d       = 1'b0;
        pix_valid_d = 1'b0;
        pix_col_d   = 3'd0;
        pix_last_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    code_d  = req_code;
                    row_d   = req_row;
                    inv_d   = inv_in;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Bit 7 goes straight out; the rest waits in the shifter.
                shreg_d     = row_data[6:0];
                pix_d       = row_data[7] ^ inv_q;
                pix_valid_d = 1'b1;
                sub_d       = 2'd0;
                rem_d       = REM_INIT;
                state_d     = SHIFT;
            end
            SHIFT, GAP: begin
                if (pix_last) begin
                    if (accept) begin
                        code_d  = req_code;
                        row_d   = req_row;
                        inv_d   = inv_in;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    pix_valid_d = 1'b1;
                    rem_d       = rem_q - 6'd1;
                    pix_last_d  = (rem_q == 6'd1);
                    if (sub_q != SCALE_M1) begin
                        sub_d     = sub_q + 2'd1;
                        pix_d     = pix;
                        pix_col_d = pix_col;
                    end else begin
                        sub_d = 2'd0;
                        if (state_q == SHIFT && pix_col != 3'd7) begin
                            shreg_d   = {shreg_q[5:0], 1'b0};
                            pix_d     = shreg_q[6] ^ inv_q;
                            pix_col_d = pix_col + 3'd1;
                        end else begin
                            state_d   = GAP;
                            pix_d     = inv_q;
                            pix_col_d = 3'd0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            row_q     <= '0;
            inv_q     <= 1'b0;
            shreg_q   <= '0;
            sub_q     <= '0;
            rem_q     <= '0;
            pix       <= 1'b0;
            pix_valid <= 1'b0;
            pix_col   <= '0;
            pix_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            row_q     <= row_d;
            inv_q     <= inv_d;
            shreg_q   <= shreg_d;
            sub_q     <= sub_d;
            rem_q     <= rem_d;
            pix       <= pix_d;
            pix_valid <= pix_valid_d;
            pix_col   <= pix_col_d;
            pix_last  <= pix_last_d;
        end
    end

endmodule

// File: doc/glyph_row_streamer.md
Name: glyph_row_streamer

Overview:
- Parametrised successor to the team's 8x16 digit font ROM.
- Accepts a (character code, glyph row) request over a valid/ready handshake and performs a registered glyph-row lookup.
- Serialises the 8-pixel row MSB-first, with horizontal pixel replication and an optional inter-glyph gap.
- Sits between the text/score layout logic and the VGA pixel mux; replaces per-pixel ROM addressing plus external bit-select.

Parameters:
- SCALE, 1, cycles each glyph pixel is held; legal 1..4.
- GAP_PX, 0, blank glyph-pixels appended after each row (each also held SCALE cycles); legal 0..7.
- FIRST_CODE, 7'h30, lowest code with a non-blank glyph.
- NUM_GLYPHS, 10, glyph count starting at FIRST_CODE; legal 1..10.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_code  in  7  ASCII character code.
- req_row  in  4  glyph row 0..15.
- pix  out  1  current pixel, 1 = foreground.
- pix_valid  out  1  pix is meaningful.
- pix_col  out  3  glyph column of current pixel 0..7; 0 during gap.
- pix_last  out  1  final output cycle of this request, including gap.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, synchronous: state=IDLE; pix, pix_valid, pix_col, pix_last, busy all 0; internal row register 0.
- req_ready is 0 while reset is high.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, latch code/row, go to FETCH.
  - FETCH, exactly 1 cycle: registered ROM read of row data into the shift register, go to SHIFT.
  - SHIFT: emits 8*SCALE cycles, bit 7 first, each bit held SCALE cycles; pix_col increments once per SCALE cycles. Then go to GAP if GAP_PX>0, else end.
  - GAP: GAP_PX*SCALE cycles with pix=0, pix_valid=1, pix_col=0.
- Latency: request accepted at edge T → FETCH in cycle T+1 → first pixel valid in cycle T+2.
- pix_last=1 on the final output cycle, i.e. the last SHIFT cycle or the last GAP cycle.
- Back-to-back: req_ready=1 also on the pix_last cycle. If a request is accepted there, go directly to FETCH; exactly one bubble cycle (pix_valid=0) separates rows. Otherwise return to IDLE.
- Request is ignored whenever req_ready=0; inputs are not sampled.
- Glyph content is the team's standard 8x16 digit font for codes 0x30..0x39:
  - Rows 0,1,12..15 are blank.
  - '0' rows 2..11 = 38,6C,C6,C6,C6,C6,C6,C6,6C,38 (hex).
  - '1' rows 2..11 = 18,38,78,18,18,18,18,18,7E,7E.
  - Remaining digits follow the same font, 7-wide blocky segments with bit 0 always 0.
- Codes outside [FIRST_CODE, FIRST_CODE+NUM_GLYPHS-1] produce an all-zero row with full normal timing (used for space/padding).
- Outputs pix, pix_col, pix_valid, pix_last are registered; no combinational path from req_* to pix*.
- Reset asserted mid-stream aborts immediately: next cycle all outputs 0 and state=IDLE. No partial row resumes.
- Per-row output count is exactly (8+GAP_PX)*SCALE valid cycles.

Optional Feature:
- Macro: GLYPH_INVERT_EN.
- Defined:
  - Adds port req_invert (in, 1), latched with the request.
  - When latched 1, every pix in SHIFT and GAP is inverted; gap pixels become 1.
  - Timing, pix_col and pix_last are unchanged.
- Undefined: no port; output is never inverted.

Test Plan:
- Reset defaults: SCALE=1, GAP_PX=0; hold reset 3 cycles → pix=pix_valid=busy=pix_last=0, req_ready=0. Release reset → req_ready=1 next cycle.
- Single request: code 0x30, row 2 → accepted at T, pix_valid from T+2 for 8 cycles, pix = 0,0,1,1,1,0,0,0, pix_col 0..7, pix_last only at T+9.
- Scaled with gap: SCALE=2, GAP_PX=1, code 0x31, row 12 → 18 valid cycles, all pix=0. Repeat with row 2 → pattern 00 00 00 11 11 00 00 00 then gap 00.
- Back-to-back and blank: '1' row 11 immediately followed by 0x41 row 5 → first pix=0,1,1,1,1,1,1,0; one bubble cycle; then 8 zero pixels with full timing.
- Reset mid-stream: assert reset during 4th pixel of '8' row 4 → next cycle all outputs 0, state IDLE. New request after release yields the full row 1,1,0,0,0,1,1,0.
- With GLYPH_INVERT_EN and req_invert=1: '0' row 2 → pix = 1,1,0,0,0,1,1,1.
